lcd_arbiter: RTL and testbench

LCD_ARBITER -- requirements
Module: lcd_arbiter

---
 rtl/lcd_arbiter_if.sv | 28 ++
 rtl/lcd_arbiter.sv | 114 +++++++++++
 tb/tb_lcd_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_arbiter_if.sv
// Requester/LCD-driver signal bundle for lcd_arbiter.
// The arbiter takes the slave view; the requesters and the LCD driver take the master view.
interface lcd_arbiter_if;
  logic       req_a;
  logic [7:0] data_a;
  logic       rs_a;
  logic       req_b;
  logic [7:0] data_b;
  logic       rs_b;
  logic       lcd_busy;
  logic       ack_a;
  logic       ack_b;
  logic       data_ready;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       grant_b;
  logic       timeout_err;

  modport master (
    output req_a, data_a, rs_a, req_b, data_b, rs_b, lcd_busy,
    input  ack_a, ack_b, data_ready, lcd_data, lcd_rs, grant_b, timeout_err
  );

  modport slave (
    input  req_a, data_a, rs_a, req_b, data_b, rs_b, lcd_busy,
    output ack_a, ack_b, data_ready, lcd_data, lcd_rs, grant_b, timeout_err
  );
endinterface

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter that serialises single-byte writes from two requesters
// onto one LCD driver, with a busy-rise timeout and sticky error flag.
module lcd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input logic          clk,
  input logic          reset_button,
  lcd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             grant_b_q, grant_b_d;
  logic             ready_q, ready_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             terr_q, terr_d;
  logic             last_b_q, last_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_b;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rs_d      = rs_q;
    grant_b_d = grant_b_q;
    ready_d   = ready_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    terr_d    = terr_q;
    last_b_d  = last_b_q;
    cnt_d     = cnt_q;
    win_b     = bus.req_b && (!bus.req_a || !last_b_q);

    unique case (state_q)
      IDLE: begin
        // The ack cycle itself is never a grant cycle, so a req still high
        // there is only treated as a new request one cycle later.
        if (!bus.lcd_busy && (bus.req_a || bus.req_b) && !(ack_a_q || ack_b_q)) begin
          grant_b_d = win_b;
          data_d    = win_b ? bus.data_b : bus.data_a;
          rs_d      = win_b ? bus.rs_b : bus.rs_a;
          ready_d   = 1'b1;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.lcd_busy) begin
          ready_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          ready_d = 1'b0;
          terr_d  = 1'b1;
          ack_a_d = !grant_b_q;
          ack_b_d = grant_b_q;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.lcd_busy) begin
          ack_a_d  = !grant_b_q;
          ack_b_d  = grant_b_q;
          last_b_d = grant_b_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_button) begin
      state_q   <= IDLE;
      data_q    <= 8'h00;
      rs_q      <= 1'b0;
      grant_b_q <= 1'b0;
      ready_q   <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      terr_q    <= 1'b0;
      last_b_q  <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      rs_q      <= rs_d;
      grant_b_q <= grant_b_d;
      ready_q   <= ready_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      terr_q    <= terr_d;
      last_b_q  <= last_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ack_a       = ack_a_q;
  assign bus.ack_b       = ack_b_q;
  assign bus.data_ready  = ready_q;
  assign bus.lcd_data    = data_q;
  assign bus.lcd_rs      = rs_q;
  assign bus.grant_b     = grant_b_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Scoreboard bench for lcd_arbiter: stimulus queues predicted transfers and acks
// from a round-robin reference model; a monitor checks what the DUT presents.
module tb_lcd_arbiter;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset_button = 1'b0;

  lcd_arbiter_if bus ();

  lcd_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk          (clk),
    .reset_button (reset_button),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic b; logic [7:0] data; logic rs; } xfer_t;
  typedef struct packed { logic b; logic terr; } ack_t;

  xfer_t       xfer_q[$];
  ack_t        ack_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic        m_last_b = 1'b1;  // model: requester served last (B after reset)
  logic        m_terr   = 1'b0;  // model: sticky timeout flag
  bit          stim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Both requesting: the one not served last wins; otherwise the lone requester.
  function automatic logic pick_b(input logic ra, input logic rb, input logic last_b);
    if (ra && rb) return (last_b == 1'b1) ? 1'b0 : 1'b1;
    return rb;
  endfunction

  task automatic check_reset_vals();
    chk("rst_data_ready", bus.data_ready, 0);
    chk("rst_ack_a", bus.ack_a, 0);
    chk("rst_ack_b", bus.ack_b, 0);
    chk("rst_grant_b", bus.grant_b, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_lcd_data", bus.lcd_data, 8'h00);
    chk("rst_lcd_rs", bus.lcd_rs, 0);
  endtask

  task automatic do_reset();
    reset_button = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset_button = 1'b1;
    m_last_b = 1'b1;
    m_terr   = 1'b0;
  endtask

  task automatic do_xfer(input bit ra, input bit rb, input logic [7:0] da, input logic rsa,
                         input logic [7:0] db, input logic rsb, input int unsigned pre_busy,
                         input int unsigned start_dly, input int unsigned busy_len,
                         input bit timeout, input bit keep, output int unsigned waits);
    xfer_t e;
    ack_t a;
    logic wb;
    int unsigned n;
    bit seen;
    bus.data_a = da; bus.rs_a = rsa; bus.data_b = db; bus.rs_b = rsb;
    bus.req_a = ra;  bus.req_b = rb;
    wb = pick_b(ra, rb, m_last_b);
    e.b = wb; e.data = wb ? db : da; e.rs = wb ? rsb : rsa;
    xfer_q.push_back(e);
    if (timeout) m_terr = 1'b1;
    a.b = wb; a.terr = m_terr;
    ack_q.push_back(a);
    if (pre_busy > 0) begin
      bus.lcd_busy = 1'b1;
      repeat (pre_busy) begin
        @(negedge clk);
        chk("no_grant_while_busy", bus.data_ready, 0);
      end
      bus.lcd_busy = 1'b0;
    end
    waits = 0; seen = 1'b0;
    while (!seen && waits < 200) begin
      @(negedge clk);
      waits++;
      seen = bus.data_ready;
    end
    if (!seen) begin
      chk("data_ready_never_rose", 0, 1);
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      return;
    end
    // inputs change after the grant; the latched byte must not follow them
    bus.data_a = $urandom; bus.data_b = $urandom; bus.rs_a = ~rsa; bus.rs_b = ~rsb;
    if (timeout) begin
      n = 1;
      while (bus.data_ready && n < 200) begin
        @(negedge clk);
        if (bus.data_ready) n++;
      end
      chk("timeout_ready_cycles", n, TO);
    end else begin
      repeat (start_dly) @(negedge clk);
      bus.lcd_busy = 1'b1;
      @(negedge clk);
      chk("ready_drops_after_busy", bus.data_ready, 0);
      repeat (busy_len - 1) @(negedge clk);
      bus.lcd_busy = 1'b0;
    end
    n = 0;
    seen = bus.ack_a | bus.ack_b;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = bus.ack_a | bus.ack_b;
    end
    if (!seen) chk("ack_never_seen", 0, 1);
    else if (!timeout) chk("ack_latency", n, 1);
    if (!timeout) m_last_b = wb;
    if (!keep) begin
      bus.req_a = 1'b0; bus.req_b = 1'b0;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer or an ack.
  initial begin
    logic  prev = 1'b0;
    xfer_t cur = '0;
    ack_t  a;
    while (!stim_done) begin
      @(negedge clk);
      if (!reset_button) begin
        prev = 1'b0;
        continue;
      end
      if (bus.ack_a | bus.ack_b) begin
        chk("ack_exclusive", bus.ack_a & bus.ack_b, 0);
        if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          a = ack_q.pop_front();
          chk("ack_b_owner", bus.ack_b, a.b);
          chk("ack_a_owner", bus.ack_a, !a.b);
          chk("timeout_err", bus.timeout_err, a.terr);
        end
      end
      if (bus.data_ready && !prev) begin
        if (xfer_q.size() == 0) chk("unexpected_data_ready", 1, 0);
        else begin
          cur = xfer_q.pop_front();
          chk("lcd_data", bus.lcd_data, cur.data);
          chk("lcd_rs", bus.lcd_rs, cur.rs);
          chk("grant_b", bus.grant_b, cur.b);
        end
      end else if (bus.data_ready) begin
        chk("lcd_data_held", bus.lcd_data, cur.data);
        chk("lcd_rs_held", bus.lcd_rs, cur.rs);
      end
      prev = bus.data_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected < 1000000", $time);
    $fatal(1);
  end

  initial begin
    int unsigned w;
    xfer_t e;
    bit seen;
    int unsigned n;
    bit ra, rb;
    bus.req_a = 0; bus.req_b = 0; bus.data_a = 0; bus.data_b = 0;
    bus.rs_a = 0; bus.rs_b = 0; bus.lcd_busy = 0;
    @(negedge clk);
    do_reset();

    // A alone, busy pulse of 5 cycles
    do_xfer(1, 0, 8'h41, 1'b1, 8'h00, 1'b0, 0, 0, 5, 0, 0, w);
    repeat (2) @(negedge clk);

    // Both held for four transfers from reset: A, B, A, B with one idle cycle between
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_xfer(1, 1, $urandom, $urandom, $urandom, $urandom, 0, 1, 2, 0, 1, w);
      chk("grant_gap_cycles", w, (i == 0) ? 1 : 2);
    end
    bus.req_a = 0; bus.req_b = 0;
    repeat (2) @(negedge clk);

    // Busy never rises: timeout, then the flag stays set across a normal transfer
    do_xfer(1, 0, $urandom, $urandom, $urandom, $urandom, 0, 0, 1, 1, 0, w);
    repeat (2) @(negedge clk);
    do_xfer(0, 1, $urandom, $urandom, $urandom, $urandom, 0, 2, 3, 0, 0, w);

    // Driver busy while B requests; B's data scrambled during ISSUE
    do_xfer(0, 1, 8'h5A, 1'b0, 8'hC3, 1'b1, 3, 3, 2, 0, 0, w);
    repeat (2) @(negedge clk);

    // Reset while in WAIT_DONE: no ack, then the first tie goes to A
    bus.data_a = $urandom; bus.data_b = $urandom;
    bus.req_a = 1; bus.req_b = 1;
    e.b = pick_b(1, 1, m_last_b);
    e.data = e.b ? bus.data_b : bus.data_a;
    e.rs = e.b ? bus.rs_b : bus.rs_a;
    xfer_q.push_back(e);
    seen = 1'b0; n = 0;
    while (!seen && n < 200) begin
      @(negedge clk); n++; seen = bus.data_ready;
    end
    if (!seen) chk("data_ready_never_rose", 0, 1);
    bus.lcd_busy = 1'b1;
    @(negedge clk);
    chk("ready_drops_after_busy", bus.data_ready, 0);
    reset_button = 1'b0;
    @(negedge clk);
    check_reset_vals();
    reset_button = 1'b1;
    bus.lcd_busy = 1'b0;
    m_last_b = 1'b1;
    m_terr = 1'b0;
    do_xfer(1, 1, $urandom, $urandom, $urandom, $urandom, 0, 0, 2, 0, 0, w);
    repeat (2) @(negedge clk);

    // Randomized episodes
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, 1);
      rb = $urandom_range(0, 1);
      if (!ra && !rb) ra = 1;
      do_xfer(ra, rb, $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(1, 4),
              ($urandom_range(0, 9) == 0), $urandom_range(0, 1), w);
    end
    bus.req_a = 0; bus.req_b = 0;
    repeat (5) @(negedge clk);
    stim_done = 1'b1;
    chk("xfer_queue_drained", xfer_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
